time_keeper_fmt: RTL
====================

TIME_KEEPER_FMT -- requirements
Module: time_keeper_fmt

Interface
REQ-001 SHALL have parameter TICK_DIV, default 100000000, clk cycles per second (legal range >= 2).
REQ-002 SHALL have parameter START_HOUR, default 0, 24 h hour loaded at reset (legal range 0..23).
REQ-003 SHALL have port clk  input  1  single clock, rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port en  input  1  count enable; 0 freezes prescaler and time.
REQ-006 SHALL have port mode12  input  1  display format: 1 = 12 h, 0 = 24 h.
REQ-007 SHALL have port set_valid  input  1  request to load set_hour/set_min/set_sec.
REQ-008 SHALL have port set_ready  output  1  block can accept a set request.
REQ-009 SHALL have port set_hour  input  5  hour to load, 24 h format.
REQ-010 SHALL have ports set_min and set_sec  input  6 each  minute and second to load.
REQ-011 SHALL have port hour  output  5  displayed hour, format per mode12.
REQ-012 SHALL have port nAM_PM  output  1  0 = AM (hour24 0..11), 1 = PM (12..23), valid in both modes.
REQ-013 SHALL have ports min and sec  output  6 each  current minute and second.
REQ-014 SHALL have port sec_pulse  output  1  one-cycle strobe on each second increment.
REQ-015 SHALL have port day_pulse  output  1  one-cycle strobe on 23:59:59 -> 00:00:00 wrap.
REQ-016 SHALL have port set_err  output  1  one-cycle strobe when a set request is rejected.

Function
REQ-017 SHALL keep internal registers prescale (ceil(log2(TICK_DIV)) bits), hour24 (0..23), min (0..59), sec (0..59).
REQ-018 SHALL, when en=1 and the FSM is in RUN, increment prescale each cycle; at prescale = TICK_DIV-1 SHALL wrap prescale to 0 and advance time by one second on that edge.
REQ-019 SHALL advance time as: sec 59 -> 0 with min+1; min 59 -> 0 with hour24+1; hour24 23 -> 0.
REQ-020 SHALL assert sec_pulse for exactly the cycle after each second advance, and day_pulse for the cycle after the 23:59:59 -> 00:00:00 advance (both high together on that cycle).
REQ-021 SHALL hold prescale and time unchanged while en=0; sec_pulse and day_pulse SHALL stay 0.
REQ-022 SHALL implement FSM states RUN and LOAD; reset enters RUN.
REQ-023 SHALL drive set_ready = 1 in RUN and 0 in LOAD.
REQ-024 SHALL accept a request when set_valid=1 and set_ready=1 on a rising edge; SHALL load only if set_hour <= 23, set_min <= 59, set_sec <= 59.
REQ-025 SHALL, on a valid request, load hour24/min/sec, clear prescale to 0, and move to LOAD; the new time SHALL be visible on outputs the next cycle.
REQ-026 SHALL, on an invalid request, leave time and prescale unchanged, stay in RUN, and pulse set_err for one cycle.
REQ-027 SHALL remain in LOAD for exactly one cycle with prescale held, then return to RUN regardless of set_valid.
REQ-028 SHALL give an accepted set priority over a coinciding second tick: the tick is discarded and sec_pulse/day_pulse are not asserted.
REQ-029 SHALL derive hour combinationally from hour24 and mode12: 24 h mode hour = hour24; 12 h mode 0 -> 12, 1..11 -> 1..11, 12 -> 12, 13..23 -> 1..11.
REQ-030 SHALL let mode12 changes affect hour immediately, without altering hour24, min, sec or prescale.
REQ-031 SHALL treat en as irrelevant to set acceptance: a set is accepted with en=0, and time stays frozen afterwards.

Reset
REQ-032 SHALL, while rst=1, force asynchronously: prescale=0, hour24=START_HOUR, min=0, sec=0, FSM=RUN, sec_pulse=0, day_pulse=0, set_err=0.
REQ-033 SHALL, on rst asserted in LOAD or mid-count, discard the pending operation; the first tick after release SHALL occur TICK_DIV enabled cycles later.

Verification (TICK_DIV=4, START_HOUR=0)
REQ-034 SHALL cover: reset, en=1 for 12 cycles -> sec=3, three sec_pulse strobes spaced 4 cycles apart.
REQ-035 SHALL cover: set 23:59:58 valid, en=1 -> set_ready low one cycle; after 8 cycles 00:00:00 with day_pulse=1 and sec_pulse=1 on the same cycle.
REQ-036 SHALL cover: set_hour sweep 0..23 with mode12=1 -> hour/nAM_PM = 12/0, 1..11/0, 12/1, 1..11/1; mode12=0 -> hour = set_hour.
REQ-037 SHALL cover: set request set_min=60 -> set_err one cycle, time unchanged, set_ready stays 1.
REQ-038 SHALL cover: set accepted on the tick edge (prescale=3) -> loaded value shown, no sec_pulse, next tick 4 cycles after LOAD exit.
REQ-039 SHALL cover: en=0 for 10 cycles mid-count, then rst pulsed during LOAD -> time frozen, then 00:00:00, set_ready=1 after release.

Source files
------------

// File: rtl/time_keeper_fmt.sv
// -----------------------------------------------------------------------------
// time_keeper_fmt
//
// Time-of-day keeper with a clock prescaler, a one-cycle set handshake and
// 12 h / 24 h display formatting.
//
// The prescaler counts enabled clk cycles. Once per TICK_DIV enabled cycles
// the time advances by one second. Internally the hour is always kept in
// 24 h form (hour24). The displayed hour is derived from hour24 and mode12
// combinationally.
//
// A set request is a valid/ready handshake:
//   - An in-range request loads the new time, clears the prescaler and
//     spends one cycle in LOAD. set_ready is low during that cycle.
//   - An out-of-range request is dropped and set_err is pulsed for one cycle.
//
// Ports
//   clk        in   clock, rising edge
//   rst        in   asynchronous active-high reset
//   en         in   count enable (0 freezes prescaler and time)
//   mode12     in   display format, 1 = 12 h, 0 = 24 h
//   set_valid  in   set request
//   set_ready  out  set request can be accepted (high in RUN)
//   set_hour   in   [4:0] hour to load, 24 h form
//   set_min    in   [5:0] minute to load
//   set_sec    in   [5:0] second to load
//   hour       out  [4:0] displayed hour, formatted per mode12
//   nAM_PM     out  0 = AM, 1 = PM (from hour24, both modes)
//   min        out  [5:0] current minute
//   sec        out  [5:0] current second
//   sec_pulse  out  strobe for the cycle after each second advance
//   day_pulse  out  strobe for the cycle after 23:59:59 -> 00:00:00
//   set_err    out  strobe for the cycle after a rejected set request
//
// FSM states
//   state   | meaning
//   --------+-------------------------------------------------------------
//   ST_RUN  | normal counting, set requests accepted
//   ST_LOAD | one-cycle settle after a load, prescaler and time held
// -----------------------------------------------------------------------------
module time_keeper_fmt #(
  parameter int unsigned TICK_DIV   = 100000000,
  parameter int unsigned START_HOUR = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       mode12,
  input  logic       set_valid,
  output logic       set_ready,
  input  logic [4:0] set_hour,
  input  logic [5:0] set_min,
  input  logic [5:0] set_sec,
  output logic [4:0] hour,
  output logic       nAM_PM,
  output logic [5:0] min,
  output logic [5:0] sec,
  output logic       sec_pulse,
  output logic       day_pulse,
  output logic       set_err
);

  // TICK_DIV >= 2 is legal, so the width is at least one bit. The guard
  // only keeps an illegal TICK_DIV of 1 from producing a zero-width vector.
  localparam int unsigned PRE_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  localparam logic [PRE_W-1:0] PRE_MAX  = PRE_W'(TICK_DIV - 1);
  localparam logic [PRE_W-1:0] PRE_ONE  = PRE_W'(1);
  localparam logic [4:0]       HOUR_RST = 5'(START_HOUR);

  localparam logic [4:0] HOUR_LAST = 5'd23;
  localparam logic [5:0] MS_LAST   = 6'd59;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_LOAD = 1'b1
  } state_t;

  state_t state_q, state_d;

  logic [PRE_W-1:0] prescale_q, prescale_d;
  logic [4:0]       hour24_q,   hour24_d;
  logic [5:0]       min_q,      min_d;
  logic [5:0]       sec_q,      sec_d;
  logic             sec_pulse_q, sec_pulse_d;
  logic             day_pulse_q, day_pulse_d;
  logic             set_err_q,   set_err_d;

  logic set_accept;
  logic set_in_range;
  logic load_ok;
  logic tick;

  logic       sec_wrap;
  logic       min_wrap;
  logic       hour_wrap;
  logic [5:0] sec_inc;
  logic [5:0] min_inc;
  logic [4:0] hour_inc;

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_RUN;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next state
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RUN:  if (load_ok) state_d = ST_LOAD;
      // LOAD always lasts exactly one cycle, whatever set_valid does.
      ST_LOAD: state_d = ST_RUN;
      default: state_d = ST_RUN;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    set_ready = 1'b0;
    case (state_q)
      ST_RUN:  set_ready = 1'b1;
      ST_LOAD: set_ready = 1'b0;
      default: set_ready = 1'b0;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Set request decode
  // ---------------------------------------------------------------------------
  always_comb begin
    set_accept   = set_valid && set_ready;
    set_in_range = (set_hour <= HOUR_LAST) && (set_min <= MS_LAST) &&
                   (set_sec <= MS_LAST);
    load_ok      = set_accept && set_in_range;
  end

  // ---------------------------------------------------------------------------
  // Time advance (next values if a second tick happens this cycle)
  // ---------------------------------------------------------------------------
  always_comb begin
    tick      = (state_q == ST_RUN) && en && (prescale_q == PRE_MAX);

    sec_wrap  = (sec_q == MS_LAST);
    min_wrap  = (min_q == MS_LAST);
    hour_wrap = (hour24_q == HOUR_LAST);

    sec_inc   = sec_wrap  ? 6'd0 : sec_q + 6'd1;
    min_inc   = min_wrap  ? 6'd0 : min_q + 6'd1;
    hour_inc  = hour_wrap ? 5'd0 : hour24_q + 5'd1;
  end

  // ---------------------------------------------------------------------------
  // Datapath next state
  // ---------------------------------------------------------------------------
  always_comb begin
    prescale_d  = prescale_q;
    hour24_d    = hour24_q;
    min_d       = min_q;
    sec_d       = sec_q;
    sec_pulse_d = 1'b0;
    day_pulse_d = 1'b0;
    set_err_d   = set_accept && !set_in_range;

    if (load_ok) begin
      // A load wins over a tick that lands on the same edge. That tick is
      // simply lost and no strobe is raised for it.
      hour24_d   = set_hour;
      min_d      = set_min;
      sec_d      = set_sec;
      prescale_d = '0;
    end else if (tick) begin
      prescale_d  = '0;
      sec_d       = sec_inc;
      sec_pulse_d = 1'b1;
      if (sec_wrap) begin
        min_d = min_inc;
        if (min_wrap) begin
          hour24_d    = hour_inc;
          day_pulse_d = hour_wrap;
        end
      end
    end else if ((state_q == ST_RUN) && en) begin
      prescale_d = prescale_q + PRE_ONE;
    end
  end

  // ---------------------------------------------------------------------------
  // Datapath registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prescale_q  <= '0;
      hour24_q    <= HOUR_RST;
      min_q       <= 6'd0;
      sec_q       <= 6'd0;
      sec_pulse_q <= 1'b0;
      day_pulse_q <= 1'b0;
      set_err_q   <= 1'b0;
    end else begin
      prescale_q  <= prescale_d;
      hour24_q    <= hour24_d;
      min_q       <= min_d;
      sec_q       <= sec_d;
      sec_pulse_q <= sec_pulse_d;
      day_pulse_q <= day_pulse_d;
      set_err_q   <= set_err_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Display formatting. This path is purely combinational, so a mode12
  // change shows on hour at once and never touches the stored time.
  // ---------------------------------------------------------------------------
  always_comb begin
    hour = hour24_q;
    if (mode12) begin
      if (hour24_q == 5'd0) begin
        hour = 5'd12;
      end else if (hour24_q > 5'd12) begin
        hour = hour24_q - 5'd12;
      end else begin
        hour = hour24_q;
      end
    end
    nAM_PM = (hour24_q >= 5'd12);
  end

  assign min       = min_q;
  assign sec       = sec_q;
  assign sec_pulse = sec_pulse_q;
  assign day_pulse = day_pulse_q;
  assign set_err   = set_err_q;

endmodule
